// File: rtl/button_debouncer.sv
// Per-channel button conditioning: two-flop synchronizer, consecutive-cycle
// debounce counter, registered stable level and one-cycle press/release strobes.
module button_debouncer #(
  parameter int width_p           = 3,
  parameter int debounce_cycles_p = 120000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] button_async_unsafe_i,
  output logic [width_p-1:0] stable_o,
  output logic [width_p-1:0] press_o,
  output logic [width_p-1:0] release_o
);

  localparam int count_width_lp = $clog2(debounce_cycles_p + 1);
  localparam logic [count_width_lp-1:0] count_last_lp = count_width_lp'(debounce_cycles_p - 1);
  localparam logic [count_width_lp-1:0] count_one_lp  = count_width_lp'(1);

  generate
    for (genvar gi = 0; gi < width_p; gi++) begin : g_chan
      logic                      sync1_reg;
      logic                      sync2_reg;
      logic [count_width_lp-1:0] count_reg;
      logic [count_width_lp-1:0] count_next;
      logic                      stable_reg;
      logic                      stable_next;
      logic                      press_reg;
      logic                      press_next;
      logic                      release_reg;
      logic                      release_next;

      // Only sync2_reg feeds the debounce decision; the raw pin never reaches an output.
      always_comb begin
        count_next   = '0;
        stable_next  = stable_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (sync2_reg != stable_reg) begin
          if (count_reg == count_last_lp) begin
            stable_next  = sync2_reg;
            press_next   = sync2_reg;
            release_next = ~sync2_reg;
          end else begin
            count_next = count_reg + count_one_lp;
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          count_reg   <= '0;
          stable_reg  <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          sync1_reg   <= button_async_unsafe_i[gi];
          sync2_reg   <= sync1_reg;
          count_reg   <= count_next;
          stable_reg  <= stable_next;
          press_reg   <= press_next;
          release_reg <= release_next;
        end
      end

      assign stable_o[gi]  = stable_reg;
      assign press_o[gi]   = press_reg;
      assign release_o[gi] = release_reg;
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Table-driven check of button_debouncer with width 3 and a 4-cycle debounce window.
module tb_button_debouncer;

  logic       clk;
  logic       reset_i;
  logic [2:0] raw;
  logic [2:0] stable_o;
  logic [2:0] press_o;
  logic [2:0] release_o;

  button_debouncer #(.width_p(3), .debounce_cycles_p(4)) dut (
    .clk_i                 (clk),
    .reset_i               (reset_i),
    .button_async_unsafe_i (raw),
    .stable_o              (stable_o),
    .press_o               (press_o),
    .release_o             (release_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       rst;
    logic [2:0] raw;
    logic [2:0] st;
    logic [2:0] pr;
    logic [2:0] rl;
  } vec_t;

  vec_t table_q[$];
  vec_t exp_q[$];
  int   checks;
  int   errors;
  int   cycle;

  task automatic add(input logic rst, input logic [2:0] r, input logic [2:0] st,
                     input logic [2:0] pr, input logic [2:0] rl, input int n);
    vec_t v;
    v.rst = rst; v.raw = r; v.st = st; v.pr = pr; v.rl = rl;
    repeat (n) table_q.push_back(v);
  endtask

  // Raw held at a new level: five quiet cycles, the flip cycle with its strobe, one settled cycle.
  task automatic transition(input logic [2:0] r, input logic [2:0] old_st, input logic [2:0] new_st);
    add(1'b0, r, old_st, 3'b000, 3'b000, 5);
    add(1'b0, r, new_st, new_st & ~old_st, old_st & ~new_st, 1);
    add(1'b0, r, new_st, 3'b000, 3'b000, 1);
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d actual %b required %b", name, cycle, act, req);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    reset_i = v.rst;
    raw     = v.raw;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    cycle++;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard cycle %0d actual empty required entry", cycle);
    end else begin
      e = exp_q.pop_front();
      check3("stable", stable_o, e.st);
      check3("press", press_o, e.pr);
      check3("release", release_o, e.rl);
      $display("cycle %0d rst %b raw %b stable %b press %b release %b", cycle, e.rst, e.raw,
               stable_o, press_o, release_o);
    end
  endtask

  task automatic hand(input logic rst, input logic [2:0] r, input logic [2:0] st,
                      input logic [2:0] pr, input logic [2:0] rl);
    vec_t v;
    v.rst = rst; v.raw = r; v.st = st; v.pr = pr; v.rl = rl;
    step(v);
  endtask

  logic [9:0] bounce_pat;

  initial begin
    checks  = 0;
    errors  = 0;
    cycle   = 0;
    reset_i = 1'b1;
    raw     = 3'b111;

    // Reset held with buttons pressed, then the held buttons register as a press.
    add(1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 2);
    transition(3'b111, 3'b000, 3'b111);
    transition(3'b000, 3'b111, 3'b000);
    // Clean press on channel 0 only.
    transition(3'b001, 3'b000, 3'b001);
    // Bounce on channel 1: 1,1,1,0,1,1,0,1,1,1 then held.
    bounce_pat = 10'b1110110111;
    for (int i = 9; i >= 0; i--)
      add(1'b0, {1'b0, bounce_pat[i], 1'b1}, 3'b001, 3'b000, 3'b000, 1);
    add(1'b0, 3'b011, 3'b001, 3'b000, 3'b000, 2);
    add(1'b0, 3'b011, 3'b011, 3'b010, 3'b000, 1);
    add(1'b0, 3'b011, 3'b011, 3'b000, 3'b000, 1);
    // Press then release channel 2.
    transition(3'b111, 3'b011, 3'b111);
    transition(3'b011, 3'b111, 3'b011);
    // Simultaneous events.
    transition(3'b000, 3'b011, 3'b000);
    transition(3'b101, 3'b000, 3'b101);
    transition(3'b011, 3'b101, 3'b011);
    transition(3'b000, 3'b011, 3'b000);

    for (int i = 0; i < table_q.size(); i++)
      step(table_q[i]);

    // Reset one cycle at E+3 of a channel-0 press: the pending count is discarded.
    hand(1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
    hand(1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
    hand(1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
    hand(1'b1, 3'b001, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 5; i++)
      hand(1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
    hand(1'b0, 3'b001, 3'b001, 3'b001, 3'b000);
    hand(1'b0, 3'b001, 3'b001, 3'b000, 3'b000);

    // Reset while stable is high clears it; the held button then presses again.
    hand(1'b1, 3'b001, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 5; i++)
      hand(1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
    hand(1'b0, 3'b001, 3'b001, 3'b001, 3'b000);
    hand(1'b0, 3'b001, 3'b001, 3'b000, 3'b000);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual %0d required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Per-button input conditioning stage placed between the raw icebreaker button pins and the gate logic driven from them (e.g. the nor2 inputs in the lab top level). Each channel synchronizes an asynchronous, bouncing, active-high button into the clock domain with a two-flop synchronizer, then requires the synchronized level to differ from the current stable level for a programmable number of consecutive cycles before accepting it. Outputs are a clean stable level per button plus single-cycle press and release strobes.

## Interface

- width_p, default 3: number of independent button channels; legal range ≥ 1.
- debounce_cycles_p, default 120000: consecutive cycles (10 ms at 12 MHz) the synchronized input must disagree with the stable level before the stable level flips; legal range ≥ 1.
- Counter width: $clog2(debounce_cycles_p + 1) bits per channel.

- clk_i, input, 1: single clock, 12 MHz on the board; all state updates on the rising edge.
- reset_i, input, 1: synchronous, active-high reset.
- button_async_unsafe_i, input, width_p: raw, asynchronous, un-debounced buttons; 1 = pressed.
- stable_o, output, width_p: debounced level per channel, registered.
- press_o, output, width_p: one-cycle strobe on a 0→1 transition of stable_o, registered.
- release_o, output, width_p: one-cycle strobe on a 1→0 transition of stable_o, registered.

## Operation

- Per channel, state: sync1, sync2 (synchronizer), count, stable, press, release. Channels are fully independent; no shared state.
- Synchronizer: sync1 <= raw; sync2 <= sync1. sync2 is the only signal the debounce logic reads. Raw input never reaches any output combinationally.
- Debounce, evaluated every rising edge when reset_i = 0:
  - sync2 == stable: count <= 0; stable unchanged.
  - sync2 != stable and count < debounce_cycles_p − 1: count <= count + 1.
  - sync2 != stable and count == debounce_cycles_p − 1: stable <= sync2; count <= 0; press <= sync2; release <= ~sync2.
  - press and release are 0 on every edge where no flip occurs.
- Any single cycle of agreement (bounce back) clears count; accumulation restarts from 0.
- count never exceeds debounce_cycles_p − 1; no wrap-around.
- press_o and release_o are never both high on the same channel.
- Reset (reset_i = 1 at a rising edge): sync1, sync2, count, stable, press, release all cleared to 0 on every channel, overriding any in-progress count or pending flip. Reset values: stable_o = 0, press_o = 0, release_o = 0.
- A button held through reset is treated as a new press after reset deasserts: stable_o rises and press_o strobes with normal latency.

## Timing

- Let edge E be the first rising edge that samples a new raw level into sync1, with raw held constant afterwards.
- sync2 takes the new level at E+1; count increments at E+2 … E+N (N = debounce_cycles_p).
- stable_o and the press_o/release_o strobe update at edge E+N+1, i.e. N+2 edges after the input change counting E as edge 1. For N = 1: flip at E+2.
- Strobe is high for exactly one cycle, aligned with the first cycle stable_o shows the new value.
- Throughput: a new transition can begin accumulating on the edge after a flip; the minimum spacing between consecutive strobes on a channel is N cycles.
- reset_i takes effect at the edge where it is sampled high; outputs read 0 in the following cycle.

## Test plan

Run all scenarios with width_p = 3, debounce_cycles_p = 4.

- Reset: hold reset_i for 2 cycles with raw = 3'b111 -> stable_o, press_o and release_o are 3'b000 throughout. After release, stable_o = 3'b111 and press_o = 3'b111 for one cycle at the 6th edge.
- Clean press: from idle, raw[0] = 1 sampled at edge E -> stable_o[0] = 1 and press_o[0] = 1 at E+5. press_o[0] = 0 at E+6. Channels 1 and 2 stay 0.
- Bounce rejection: raw[1] pattern 1,1,1,0,1,1,0,1,1,1 per cycle -> no change on stable_o[1] and no strobes. Then hold raw[1] = 1 -> flip exactly 6 edges after the last 0→1 sample.
- Release: with stable_o[2] = 1, drop raw[2] to 0 and hold -> stable_o[2] = 0 and release_o[2] = 1 for one cycle, 6 edges later. press_o[2] stays 0.
- Simultaneous events: raw goes 3'b000 → 3'b101 on one edge -> press_o = 3'b101 for one cycle on the same edge. Then raw = 3'b011 -> press_o = 3'b010 and release_o = 3'b100 together, 6 edges later.
- Reset mid-count: raw[0] = 1 held, assert reset_i for 1 cycle at E+3 -> no strobe at E+5, count cleared. The flip occurs 6 edges after the first post-reset sample of raw.
